register_file: RTL and testbench

- 32-entry general-purpose register file for the RV32I monocycle core.
- Sits between the instruction decoder, which supplies rs1/rs2/rd, and the ALU/writeback path.
- Two asynchronous read ports and one synchronous write port; x0 is hardwired to zero.
- Each storage entry is an instance of the existing enable-gated register_n_bits block.

---
 rtl/riscv_pkg.sv | 9 +
 rtl/register_file_if.sv | 23 ++
 rtl/register_n_bits.sv | 18 +
 rtl/register_file.sv | 40 ++++
 tb/tb_register_file.sv | 123 ++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I register-file constants and types
package riscv_pkg;
   localparam int REG_COUNT = 32;
   localparam int REG_ADDR_WIDTH = 5;
   localparam int XLEN = 32;
   localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG = 5'd0;
   typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
   typedef logic [XLEN-1:0] xlen_t;
endpackage

// File: rtl/register_file_if.sv
// register_file_if: write port plus two read ports of the register file
interface register_file_if
   import riscv_pkg::*;
#(
   parameter int DATA_WIDTH = XLEN,
   parameter int ADDR_WIDTH = REG_ADDR_WIDTH
);
   logic                  write_enable_i;
   logic [ADDR_WIDTH-1:0] write_addr_i;
   logic [DATA_WIDTH-1:0] write_data_i;
   logic [ADDR_WIDTH-1:0] read_addr1_i;
   logic [ADDR_WIDTH-1:0] read_addr2_i;
   logic [DATA_WIDTH-1:0] read_data1_o;
   logic [DATA_WIDTH-1:0] read_data2_o;
   modport master (
      output write_enable_i, write_addr_i, write_data_i, read_addr1_i, read_addr2_i,
      input  read_data1_o, read_data2_o
   );
   modport slave (
      input  write_enable_i, write_addr_i, write_data_i, read_addr1_i, read_addr2_i,
      output read_data1_o, read_data2_o
   );
endinterface

// File: rtl/register_n_bits.sv
// register_n_bits: enable-gated storage register with synchronous active-low clear
module register_n_bits #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  write_enable_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic [DATA_WIDTH-1:0] data_o
);
   logic [DATA_WIDTH-1:0] r_q;
   // clear wins over a pending write; otherwise load only when enabled
   always_ff @(posedge clk_i) begin
      if (!rst_i) r_q <= '0;
      else if (write_enable_i) r_q <= data_i;
   end
   assign data_o = r_q;
endmodule

// File: rtl/register_file.sv
// register_file: 32-entry RV32I register file, two async reads, one sync write, x0 tied to zero
module register_file
   import riscv_pkg::*;
#(
   parameter int DATA_WIDTH = XLEN,
   parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
   parameter int BYPASS_EN  = 0
) (
   input  logic clk_i,
   input  logic rst_i,
   register_file_if.slave bus
);
   localparam int N = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(ZERO_REG);
   logic [DATA_WIDTH-1:0] w_q [N];
   logic                  w_byp_ok;
   assign w_q[0] = '0;
   genvar g;
   generate
      for (g = 1; g < N; g++) begin : g_entry
         register_n_bits #(.DATA_WIDTH(DATA_WIDTH)) u_reg (
            .clk_i          (clk_i),
            .rst_i          (rst_i),
            .write_enable_i (bus.write_enable_i && (bus.write_addr_i == ADDR_WIDTH'(g))),
            .data_i         (bus.write_data_i),
            .data_o         (w_q[g])
         );
      end
   endgenerate
   assign w_byp_ok = (BYPASS_EN != 0) && rst_i && bus.write_enable_i && (bus.write_addr_i != ZERO);
   // x0 reads zero first, then write-first forwarding, then stored contents
   always_comb begin
      bus.read_data1_o = (bus.read_addr1_i == ZERO) ? '0 :
                         (w_byp_ok && bus.read_addr1_i == bus.write_addr_i) ? bus.write_data_i :
                         w_q[bus.read_addr1_i];
      bus.read_data2_o = (bus.read_addr2_i == ZERO) ? '0 :
                         (w_byp_ok && bus.read_addr2_i == bus.write_addr_i) ? bus.write_data_i :
                         w_q[bus.read_addr2_i];
   end
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed checks of read-first and write-first register files side by side
module tb_register_file;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;
   register_file_if bus0 ();
   register_file_if bus1 ();
   register_file #(.BYPASS_EN(0)) dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0.slave));
   register_file #(.BYPASS_EN(1)) dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1.slave));
   assign bus1.write_enable_i = bus0.write_enable_i;
   assign bus1.write_addr_i   = bus0.write_addr_i;
   assign bus1.write_data_i   = bus0.write_data_i;
   assign bus1.read_addr1_i   = bus0.read_addr1_i;
   assign bus1.read_addr2_i   = bus0.read_addr2_i;
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      bus0.write_enable_i = 1'b1;
      bus0.write_addr_i   = a;
      bus0.write_data_i   = d;
      tick();
      bus0.write_enable_i = 1'b0;
   endtask
   task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
      bus0.read_addr1_i = a1;
      bus0.read_addr2_i = a2;
      #1;
   endtask
   task automatic chk_all(input string tag, input logic [31:0] e0, input logic [31:0] e1);
      chk({tag, " d0p1"}, bus0.read_data1_o, e0);
      chk({tag, " d0p2"}, bus0.read_data2_o, e0);
      chk({tag, " d1p1"}, bus1.read_data1_o, e1);
      chk({tag, " d1p2"}, bus1.read_data2_o, e1);
   endtask
   initial begin
      bus0.write_enable_i = 1'b0;
      bus0.write_addr_i   = '0;
      bus0.write_data_i   = '0;
      bus0.read_addr1_i   = '0;
      bus0.read_addr2_i   = '0;
      tick();
      tick();
      rst = 1'b1;
      for (int i = 0; i < 32; i++) begin
         rd(5'(i), 5'(31 - i));
         chk_all($sformatf("init x%0d", i), 32'h0, 32'h0);
      end
      wr(5, 32'hDEADBEEF);
      rd(5, 5);
      chk_all("pre x5", 32'hDEADBEEF, 32'hDEADBEEF);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      for (int i = 0; i < 32; i++) begin
         rd(5'(i), 5'(i));
         chk_all($sformatf("rst x%0d", i), 32'h0, 32'h0);
      end
      wr(1, 32'h12345678);
      rd(1, 1);
      chk_all("wr x1", 32'h12345678, 32'h12345678);
      wr(31, 32'hFEDCBA98);
      rd(1, 31);
      chk("wr x1 d0", bus0.read_data1_o, 32'h12345678);
      chk("wr x31 d0", bus0.read_data2_o, 32'hFEDCBA98);
      chk("wr x1 d1", bus1.read_data1_o, 32'h12345678);
      chk("wr x31 d1", bus1.read_data2_o, 32'hFEDCBA98);
      bus0.write_enable_i = 1'b1;
      bus0.write_addr_i   = 0;
      bus0.write_data_i   = 32'hFFFFFFFF;
      rd(0, 0);
      chk_all("x0 pre", 32'h0, 32'h0);
      tick();
      chk_all("x0 post", 32'h0, 32'h0);
      bus0.write_enable_i = 1'b0;
      wr(3, 32'h11111111);
      bus0.write_addr_i = 3;
      bus0.write_data_i = 32'h01010101;
      repeat (3) tick();
      rd(3, 3);
      chk_all("gate x3", 32'h11111111, 32'h11111111);
      wr(7, 32'hAAAA0000);
      bus0.write_enable_i = 1'b1;
      bus0.write_addr_i   = 7;
      bus0.write_data_i   = 32'h0000BBBB;
      rd(7, 7);
      chk_all("same pre", 32'hAAAA0000, 32'h0000BBBB);
      tick();
      bus0.write_enable_i = 1'b0;
      #1;
      chk_all("same post", 32'h0000BBBB, 32'h0000BBBB);
      rst = 1'b0;
      bus0.write_enable_i = 1'b1;
      bus0.write_addr_i   = 9;
      bus0.write_data_i   = 32'h5A5A5A5A;
      rd(9, 7);
      chk("rst byp x9 d1", bus1.read_data1_o, 32'h0);
      chk("rst byp x7 d1", bus1.read_data2_o, 32'h0000BBBB);
      tick();
      rst = 1'b1;
      bus0.write_enable_i = 1'b0;
      rd(9, 7);
      chk("rstwr x9 d0", bus0.read_data1_o, 32'h0);
      chk("rstwr x9 d1", bus1.read_data1_o, 32'h0);
      chk("rstwr x7 d0", bus0.read_data2_o, 32'h0);
      chk("rstwr x7 d1", bus1.read_data2_o, 32'h0);
      wr(9, 32'h5A5A5A5A);
      rd(9, 9);
      chk_all("rewr x9", 32'h5A5A5A5A, 32'h5A5A5A5A);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
